// File: rtl/fd_circle_fetch.sv
// FAST corner front end: builds a 7x7 neighbourhood from a raster pixel stream using 6 line buffers
// and presents the centre pixel, the 16 radius-3 circle pixels and the frame threshold per interior pixel.
module fd_circle_fetch #(
  parameter int unsigned IMG_WIDTH  = 180,
  parameter int unsigned IMG_HEIGHT = 120,
  parameter int unsigned XW         = 8,
  parameter int unsigned YW         = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  input  logic          frame_start,
  input  logic [7:0]    threshold_in,
  output logic [7:0]    ref_pxl,
  output logic [127:0]  circle_pxl,
  output logic [7:0]    threshold_out,
  output logic          win_valid,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y
);

  localparam int unsigned NLB    = 6;
  localparam int unsigned WIN    = 7;
  localparam int unsigned PW     = 8;
  localparam int unsigned EDGE   = 6;
  localparam int unsigned RADIUS = 3;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t          state;
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic [PW-1:0]   thr_q;

  logic [PW-1:0]   lb_mem [NLB][IMG_WIDTH];
  logic [PW-1:0]   lb_rd  [NLB];
  logic [PW-1:0]   lb_wr  [NLB];
  logic [PW-1:0]   win     [WIN][WIN];
  logic [PW-1:0]   win_nxt [WIN][WIN];
  logic [127:0]    circle_nxt;

  logic            accept;
  logic [XW-1:0]   cur_x;
  logic [YW-1:0]   cur_y;
  logic            last_col;
  logic            last_row;
  logic            interior;

  // A frame_start beat is accepted in any state and restarts the raster at (0,0)
  always_comb begin
    accept   = pix_valid && (frame_start || (state == ACTIVE));
    cur_x    = frame_start ? '0 : x_cnt;
    cur_y    = frame_start ? '0 : y_cnt;
    last_col = (cur_x == XW'(IMG_WIDTH - 1));
    last_row = (cur_y == YW'(IMG_HEIGHT - 1));
    interior = (cur_x >= XW'(EDGE)) && (cur_y >= YW'(EDGE));
  end

  // Line-buffer chain: read-before-write at the current column, each buffer feeds the next
  always_comb begin
    for (int n = 0; n < NLB; n++) begin
      lb_rd[n] = lb_mem[n][cur_x];
    end
    lb_wr[0] = pix_in;
    for (int n = 1; n < NLB; n++) begin
      lb_wr[n] = lb_rd[n-1];
    end
  end

  for (genvar n = 0; n < NLB; n++) begin : g_lb
    always_ff @(posedge clk) begin
      if (accept) begin
        lb_mem[n][cur_x] <= lb_wr[n];
      end
    end
  end

  // Window shifts left; row 6 of the new column is the live pixel, row 6-1-n comes from buffer n
  always_comb begin
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
    end
    for (int r = 0; r < WIN - 1; r++) begin
      win_nxt[r][WIN-1] = lb_rd[NLB-1-r];
    end
    win_nxt[WIN-1][WIN-1] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      win <= win_nxt;
    end
  end

  // Bresenham radius-3 circle, clockwise from the top; entries are win_nxt[3+dy][3+dx]
  always_comb begin
    circle_nxt            = '0;
    circle_nxt[  0 +: 8]  = win_nxt[0][3];
    circle_nxt[  8 +: 8]  = win_nxt[0][4];
    circle_nxt[ 16 +: 8]  = win_nxt[1][5];
    circle_nxt[ 24 +: 8]  = win_nxt[2][6];
    circle_nxt[ 32 +: 8]  = win_nxt[3][6];
    circle_nxt[ 40 +: 8]  = win_nxt[4][6];
    circle_nxt[ 48 +: 8]  = win_nxt[5][5];
    circle_nxt[ 56 +: 8]  = win_nxt[6][4];
    circle_nxt[ 64 +: 8]  = win_nxt[6][3];
    circle_nxt[ 72 +: 8]  = win_nxt[6][2];
    circle_nxt[ 80 +: 8]  = win_nxt[5][1];
    circle_nxt[ 88 +: 8]  = win_nxt[4][0];
    circle_nxt[ 96 +: 8]  = win_nxt[3][0];
    circle_nxt[104 +: 8]  = win_nxt[2][0];
    circle_nxt[112 +: 8]  = win_nxt[1][1];
    circle_nxt[120 +: 8]  = win_nxt[0][2];
  end

  // Frame FSM, raster counters, threshold latch and registered window outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      x_cnt         <= '0;
      y_cnt         <= '0;
      thr_q         <= '0;
      ref_pxl       <= '0;
      circle_pxl    <= '0;
      threshold_out <= '0;
      win_valid     <= 1'b0;
      win_x         <= '0;
      win_y         <= '0;
    end else begin
      win_valid <= 1'b0;
      if (accept) begin
        if (frame_start) begin
          thr_q <= threshold_in;
        end
        if (last_col) begin
          x_cnt <= '0;
          y_cnt <= last_row ? '0 : cur_y + YW'(1);
        end else begin
          x_cnt <= cur_x + XW'(1);
          y_cnt <= cur_y;
        end
        state <= (last_col && last_row) ? DONE : ACTIVE;
        if (interior) begin
          win_valid     <= 1'b1;
          win_x         <= cur_x - XW'(RADIUS);
          win_y         <= cur_y - YW'(RADIUS);
          ref_pxl       <= win_nxt[RADIUS][RADIUS];
          circle_pxl    <= circle_nxt;
          threshold_out <= thr_q;
        end
      end
    end
  end

endmodule
